// File: rtl/data_mem_bridge_pkg.sv
// Shared encodings for the data-memory bridge: access sizes, FSM states and
// the default bus timeout used when BUS_TIMEOUT_EN is defined.
package data_mem_bridge_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned TIMEOUT_CYC_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables and write replication for stores,
// lane extraction with sign/zero extension for loads, plus alignment check.
module mem_lane_align
    import data_mem_bridge_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted    = rdata_i >> {addr_lo_i, 3'b000};
        be_o       = 4'b0000;
        wdata_o    = wdata_i;
        rdata_o    = shifted;
        misalign_o = 1'b0;
        unique case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
                misalign_o = addr_lo_i[0];
            end
            SZ_WORD: begin
                be_o       = 4'b1111;
                misalign_o = (addr_lo_i != 2'b00);
            end
            default: begin
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_bridge.sv
// Core data port to req/ack bus bridge with stall and load extension.
// Optional BUS_TIMEOUT_EN aborts a BUSY transfer after TIMEOUT_CYC cycles.
module data_mem_bridge
    import data_mem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [1:0]        core_size,
    input  logic              core_sign_ext,
    input  logic              core_rd_en,
    input  logic              core_wr_en,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic              core_stall,
    output logic              core_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [31:0]       bus_rdata
);

    state_e            state_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [3:0]        bus_be_q;
    logic [31:0]       bus_wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [1:0]        addr_lo_q;
    logic [1:0]        size_q;
    logic              sign_q;

    logic              req_valid;
    logic              bad_req;
    logic [1:0]        la_addr_lo;
    logic [1:0]        la_size;
    logic              la_sign;
    logic [3:0]        la_be;
    logic [31:0]       la_wdata;
    logic [31:0]       la_rdata;
    logic              la_misalign;

    // In BUSY the lane logic must see the latched access, not the live core inputs.
    always_comb begin
        la_addr_lo = core_addr[1:0];
        la_size    = core_size;
        la_sign    = core_sign_ext;
        if (state_q == ST_BUSY) begin
            la_addr_lo = addr_lo_q;
            la_size    = size_q;
            la_sign    = sign_q;
        end
    end

    mem_lane_align u_lane_align (
        .addr_lo_i  (la_addr_lo),
        .size_i     (la_size),
        .sign_ext_i (la_sign),
        .wdata_i    (core_wdata),
        .rdata_i    (bus_rdata),
        .be_o       (la_be),
        .wdata_o    (la_wdata),
        .rdata_o    (la_rdata),
        .misalign_o (la_misalign)
    );

    assign req_valid = core_rd_en | core_wr_en;
    assign bad_req   = la_misalign | (core_rd_en & core_wr_en);

    always_comb begin
        core_stall = 1'b0;
        if (rst) begin
            core_stall = (state_q == ST_BUSY) ||
                         ((state_q == ST_IDLE) && req_valid && !bad_req);
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic [31:0] cnt_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            addr_lo_q   <= 2'b00;
            size_q      <= SZ_BYTE;
            sign_q      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (bad_req) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= core_wr_en;
                            bus_addr_q  <= {core_addr[ADDR_W-1:2], 2'b00};
                            bus_be_q    <= la_be;
                            bus_wdata_q <= la_wdata;
                            addr_lo_q   <= core_addr[1:0];
                            size_q      <= core_size;
                            sign_q      <= core_sign_ext;
                            state_q     <= ST_BUSY;
`ifdef BUS_TIMEOUT_EN
                            cnt_q       <= '0;
`endif
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        rdata_q   <= bus_we_q ? 32'h0 : la_rdata;
                        err_q     <= bus_err;
                        state_q   <= ST_DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (cnt_q + 32'd1 >= TIMEOUT_CYC) begin
                        bus_req_q <= 1'b0;
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
`endif
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;
    assign core_rdata = rdata_q;
    assign core_err   = err_q;

endmodule
